ext_irq_controller: RTL
=======================

// Module: ext_irq_controller
// PURPOSE
//  Upstream interrupt front-end for processor_arm: collects NSRC external async
//  interrupt lines, synchronizes and edge-detects them, latches pending requests,
//  and presents a single held ExtIRQ request plus source id to the core.
//  Handshakes with the core's exception entry (irq_ack) and return (irq_eoi).
// PARAMETERS
//  NSRC        4   number of external interrupt sources (2..16)
//  SYNC_STAGES 2   synchronizer flops per source (>=2)
//  IDW         2   width of irq_id; must equal $clog2(NSRC)
// PORTS
//  CLOCK_50   in   1      system clock, all logic on rising edge
//  reset      in   1      asynchronous, active-low; clears all state
//  irq_in     in   NSRC   raw async lines, rising edge = request
//  irq_mask   in   NSRC   1 = source enabled for forwarding
//  irq_ack    in   1      core took exception; 1-cycle pulse
//  irq_eoi    in   1      core finished handler (ERET); 1-cycle pulse
//  ExtIRQ     out  1      registered request to core
//  irq_id     out  IDW    source being requested/serviced
//  irq_pend   out  NSRC   pending vector (status)
//  irq_ovr    out  NSRC   sticky overrun flags (status)
// BEHAVIOUR
//  Reset (reset=0): sync chains, edge regs, irq_pend, irq_ovr = 0; ExtIRQ=0;
//   irq_id=0; state=IDLE. Applies immediately, mid-handshake included.
//  Input: irq_in pulses must be >=1 CLOCK_50 period wide; narrower pulses
//   are not guaranteed to be captured.
//  Edge detect: edge[i] = sync_out[i] & ~prev[i]; prev registers sync_out.
//  Pending: edge[i] sets irq_pend[i] regardless of mask. Cleared only on
//   irq_ack in REQ for i==irq_id. Same-cycle set and clear on same bit: set wins.
//  Overrun: edge[i] while irq_pend[i]=1 sets irq_ovr[i]; cleared with pend clear
//   (set wins if simultaneous).
//  Latency: irq_in first sampled high at edge t0 -> irq_pend set at
//   t0+SYNC_STAGES, ExtIRQ=1 at t0+SYNC_STAGES+1 (IDLE, source unmasked).
//  FSM:
//   IDLE: ExtIRQ=0. If |(irq_pend & irq_mask): irq_id <= lowest set index,
//    ExtIRQ <= 1, -> REQ. Else stay.
//   REQ: ExtIRQ held 1, irq_id stable. On irq_ack: clear irq_pend[irq_id],
//    ExtIRQ <= 0, -> SERVICE. Mask change in REQ does not withdraw request.
//   SERVICE: ExtIRQ=0, irq_id holds serviced source. On irq_eoi -> IDLE;
//    next request earliest one cycle after return to IDLE (no nesting).
//  irq_ack outside REQ and irq_eoi outside SERVICE: ignored, no state change.
//  irq_ack and irq_eoi same cycle: only the one valid for current state acts.
//  Priority: fixed, index 0 highest; arbitration only in IDLE.
//  All outputs registered; no combinational path input -> output.
// TESTING
//  1 reset low mid-REQ -> next cycle ExtIRQ=0, irq_pend=0, irq_ovr=0, IDLE.
//  2 irq_in[2] high 2 cycles at t0, mask=4'hF -> ExtIRQ=1 at t0+3, irq_id=2;
//    irq_ack -> ExtIRQ=0, irq_pend=0; irq_eoi -> IDLE, no re-request.
//  3 irq_in[1] and irq_in[3] rise same cycle -> irq_id=1 first; after ack+eoi,
//    ExtIRQ re-asserts with irq_id=3.
//  4 mask=4'b1110, irq_in[0] rises -> irq_pend=4'b0001, ExtIRQ stays 0;
//    mask -> 4'hF -> ExtIRQ=1, irq_id=0 next cycle.
//  5 source 2 pending, second edge on irq_in[2] before ack -> irq_ovr[2]=1;
//    irq_ack -> irq_pend[2]=0, irq_ovr[2]=0.
//  6 irq_ack in IDLE, irq_eoi in REQ -> ignored; ExtIRQ/irq_pend unchanged.

Source files
------------

// File: rtl/ext_irq_controller.sv
// External interrupt front-end: synchronizes and edge-detects async lines, latches pending
// requests and presents one held request (ExtIRQ + irq_id) to the core with ack/eoi handshake.
module ext_irq_controller #(
    parameter int unsigned NSRC        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDW         = 2
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            irq_ack,
    input  logic            irq_eoi,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] irq_pend,
    output logic [NSRC-1:0] irq_ovr
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e          state;
    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] sync_out;
    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] active;
    logic [IDW-1:0]  lowest;
    logic            any_active;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~prev_q;

    // Only an accepted ack clears the bit of the source being requested.
    always_comb begin
        clr = '0;
        if (state == StReq && irq_ack) clr[irq_id] = 1'b1;
    end

    assign active     = irq_pend & irq_mask;
    assign any_active = |active;

    always_comb begin
        lowest = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) lowest = IDW'(i);
        end
    end

    // Set terms are ORed in after the clear so a simultaneous new edge wins.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            irq_pend <= '0;
            irq_ovr  <= '0;
        end else begin
            irq_pend <= (irq_pend & ~clr) | edge_det;
            irq_ovr  <= (irq_ovr & ~clr) | (edge_det & irq_pend);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state  <= StIdle;
            ExtIRQ <= 1'b0;
            irq_id <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_active) begin
                        irq_id <= lowest;
                        ExtIRQ <= 1'b1;
                        state  <= StReq;
                    end
                end
                StReq: begin
                    if (irq_ack) begin
                        ExtIRQ <= 1'b0;
                        state  <= StService;
                    end
                end
                StService: begin
                    if (irq_eoi) state <= StIdle;
                end
                default: begin
                    ExtIRQ <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

endmodule
